// File: rtl/bit_serial_subtractor_if.sv
// rtl/bit_serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
//
// Purpose: groups the operand request and registered result signals of
// bit_serial_subtractor so the wrapper and the core share one connection.
//
// Signals:
//   start       request, sampled by the core only while idle
//   a_in        minuend, captured on the accepted start cycle
//   b_in        subtrahend, captured on the accepted start cycle
//   busy        high while an operation is in flight (SHIFT or DONE)
//   done        one-cycle pulse, result valid from this cycle on
//   diff_out    registered difference
//   borrow_out  registered final borrow (1 when A < B)
//   zero_out    registered diff_out == 0 flag
//
// Modports:
//   master  drives the request, observes the result (wrapper / bench side)
//   slave   consumes the request, drives the result (subtractor core side)

interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             zero_out;

  modport master (
    output start,
    output a_in,
    output b_in,
    input  busy,
    input  done,
    input  diff_out,
    input  borrow_out,
    input  zero_out
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    output busy,
    output done,
    output diff_out,
    output borrow_out,
    output zero_out
  );

endinterface

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - bit-serial unsigned subtractor D = A - B, LSB first
//
// Purpose: one full-subtractor cell plus a borrow flop, resolving one result
// bit per clock. An accepted start captures both operands; WIDTH shift
// cycles follow, then a single DONE cycle pulses done. Results are modulo
// 2^WIDTH with the final borrow reported separately.
//
// Timing: the accepting edge ends cycle 0, done is high in cycle WIDTH+1,
// and back-to-back operations complete once every WIDTH+2 cycles.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   bit_serial_subtractor_if.slave (start, a_in, b_in, busy, done,
//         diff_out, borrow_out, zero_out)
//
// Parameters:
//   WIDTH  operand/result width in bits, 2..16
//
// Build option:
//   SERIAL_SUB_SATURATE_EN  when defined, a result with final borrow = 1 is
//                           floored to zero (diff_out = 0, borrow_out = 1,
//                           zero_out = 1). Undefined: wrapped result.

module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  bit_serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // datapath state
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bw;
  logic [CW-1:0]    cnt;

  // registered results
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  // FSM decode
  logic load_op;
  logic shift_en;
  logic last_bit;
  logic busy_c;
  logic done_c;

  // full-subtractor cell
  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;

  // final result selection
  logic [WIDTH-1:0] fin_diff;
  logic             fin_zero;

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign d_bit    = a0 ^ b0 ^ bw;
  assign bw_next  = (~a0 & b0) | (~(a0 ^ b0) & bw);
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  assign res_next = {d_bit, res_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_SATURATE_EN
  assign fin_diff = bw_next ? '0 : res_next;
`else
  assign fin_diff = res_next;
`endif
  assign fin_zero = (fin_diff == '0);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load_op    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_c   = 1'b1;
        shift_en = 1'b1;
        if (cnt == '0) begin
          last_bit   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start seen here is deliberately dropped: acceptance only happens
        // in IDLE, which keeps the spacing at WIDTH+2 cycles.
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      bw       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      if (load_op) begin
        a_sh   <= bus.a_in;
        b_sh   <= bus.b_in;
        res_sh <= '0;
        bw     <= 1'b0;
        cnt    <= CW'(WIDTH - 1);
      end else if (shift_en) begin
        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        res_sh <= res_next;
        bw     <= bw_next;
        if (!last_bit) begin
          cnt <= cnt - CW'(1);
        end
      end

      // Results are loaded on the edge that enters DONE so they are already
      // valid while done is high; otherwise they hold across operations.
      if (last_bit) begin
        diff_q   <= fin_diff;
        borrow_q <= bw_next;
        zero_q   <= fin_zero;
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.diff_out   = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero_out   = zero_q;

endmodule
